// File: rtl/grant_pkg.sv
// Shared helpers for the grant multiplexer: grant validity check,
// one-hot to index encode and the index-width derivation.
package grant_pkg;

  // Widest grant vector the helpers accept; callers zero-extend.
  localparam int MAX_PORTS     = 32;
  localparam int DEFAULT_PORTS = 3;

  typedef logic [MAX_PORTS-1:0] port_vec_t;

  // Bits needed to index NUM_PORTS ports (at least one).
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Index width for the default port count.
  localparam int IDX_W = idx_width(DEFAULT_PORTS);

  // True when the vector has no bit or exactly one bit set.
  function automatic logic is_zero_or_onehot(input port_vec_t v);
    return (v & (v - port_vec_t'(1))) == '0;
  endfunction

  // Position of the set bit of a one-hot vector (0 for an all-zero vector).
  function automatic int onehot_index(input port_vec_t v);
    int idx;
    idx = 0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (v[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_mux_fifo.sv
// Two-entry skid FIFO carrying {last, data}. The push-side ready is a
// register that is high exactly when the FIFO will not be full, so the
// upstream sees no combinational path from the pop side.
module grant_mux_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH:0]   i_push_data,
  input  logic                  i_pop,
  output logic                  o_empty,
  output logic                  o_nonempty_next,
  output logic [DATA_WIDTH:0]   o_head
);

  logic [DATA_WIDTH:0] r_mem [0:1];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                r_ready;

  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_count_next;

  assign w_push = i_push_valid & r_ready;
  assign w_pop  = i_pop & (r_count != 2'd0);

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_next;
      r_ready <= (w_count_next != 2'd2);
    end
  end

  // Beat storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_push_ready    = r_ready;
  assign o_empty         = (r_count == 2'd0);
  assign o_nonempty_next = (w_count_next != 2'd0);
  assign o_head          = r_mem[r_rd_ptr];

endmodule

// File: rtl/grant_mux.sv
// Grant-driven stream multiplexer: one skid FIFO per upstream port, a
// held request per port while a packet is open, and a single output
// register fed from whichever port the external arbiter grants.
module grant_mux
  import grant_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [0:NUM_PORTS-1]            request,
  input  logic [0:NUM_PORTS-1]            grant,
  input  logic [0:NUM_PORTS-1]            s_valid,
  output logic [0:NUM_PORTS-1]            s_ready,
  input  logic [0:NUM_PORTS-1]            s_last,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  output logic                            err_grant
);

  localparam int PORT_IDX_W = idx_width(NUM_PORTS);

  logic [DATA_WIDTH:0]     w_head [0:NUM_PORTS-1];
  logic [0:NUM_PORTS-1]    w_empty;
  logic [0:NUM_PORTS-1]    w_nonempty_next;
  logic [0:NUM_PORTS-1]    w_ready;
  logic [0:NUM_PORTS-1]    w_push;
  logic [0:NUM_PORTS-1]    w_pop;
  logic [0:NUM_PORTS-1]    w_in_pkt_next;
  logic [0:NUM_PORTS-1]    w_request_next;

  logic [0:NUM_PORTS-1]    r_in_pkt;
  logic [0:NUM_PORTS-1]    r_request;
  logic                    r_m_valid;
  logic                    r_m_last;
  logic [DATA_WIDTH-1:0]   r_m_data;

  port_vec_t               w_grant_vec;
  logic                    w_grant_ok;
  logic                    w_grant_bad;
  logic [PORT_IDX_W-1:0]   w_sel;
  logic                    w_move;

  // Re-pack the grant so bit k of the helper vector is port k.
  always_comb begin
    w_grant_vec = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_grant_vec[k] = grant[k];
    end
  end

  assign w_grant_bad = ~is_zero_or_onehot(w_grant_vec);
  assign w_grant_ok  = (grant != '0) & ~w_grant_bad;
  assign w_sel       = PORT_IDX_W'(onehot_index(w_grant_vec));

  // A beat moves only under a clean single grant into a free or draining slot.
  assign w_move = w_grant_ok & ~w_empty[w_sel] & (~r_m_valid | m_ready);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      grant_mux_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .i_push_valid    (s_valid[gi]),
        .o_push_ready    (w_ready[gi]),
        .i_push_data     ({s_last[gi], s_data[(NUM_PORTS-gi)*DATA_WIDTH-1 -: DATA_WIDTH]}),
        .i_pop           (w_pop[gi]),
        .o_empty         (w_empty[gi]),
        .o_nonempty_next (w_nonempty_next[gi]),
        .o_head          (w_head[gi])
      );

      assign w_push[gi] = s_valid[gi] & w_ready[gi];
      assign w_pop[gi]  = w_move & (w_sel == PORT_IDX_W'(gi));

      // A fresh beat opens (or keeps open) the packet; a last beat leaving closes it.
      assign w_in_pkt_next[gi] = w_push[gi] ? 1'b1 :
                                 (w_pop[gi] & w_head[gi][DATA_WIDTH]) ? 1'b0 :
                                 r_in_pkt[gi];
      assign w_request_next[gi] = w_nonempty_next[gi] | w_in_pkt_next[gi];
    end
  endgenerate

  // Packet-open flags and registered requests for every port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_pkt  <= '0;
      r_request <= '0;
    end else begin
      r_in_pkt  <= w_in_pkt_next;
      r_request <= w_request_next;
    end
  end

  // Output register: load on a move, hold while stalled, empty when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_move) begin
      r_m_valid <= 1'b1;
      {r_m_last, r_m_data} <= w_head[w_sel];
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign request   = r_request;
  assign s_ready   = w_ready;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign m_data    = r_m_data;
  // Flags the offending cycle itself; forced low while in reset.
  assign err_grant = ~rst & w_grant_bad;

endmodule
